sha256_block_sched: RTL

Sequencer for the SHA-256 compression datapath inside the axi_sha256 IP. It sits between the AXI-lite register/FIFO front end and the round core. For each block it:
- optionally loads the IV;
- streams 16 message words into rounds 0–15;
- runs schedule-expansion rounds 16–63;
- triggers the final hash add;
- raises a done pulse and a level interrupt that stays set until acknowledged.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_block_sched_if.sv | 34 +++
 rtl/sha256_irq_reg.sv | 27 ++
 rtl/sha256_block_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: sequencer states, block geometry, round-index type
// and the IV / K constants read by the round core.
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;
  localparam int CNT_W     = 16;

  typedef logic [5:0] round_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_IV = 3'd1,
    ST_FILL    = 3'd2,
    ST_EXPAND  = 3'd3,
    ST_FINAL   = 3'd4,
    ST_DONE    = 3'd5
  } sha256_sched_state_t;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_k(input round_idx_t t);
    return SHA256_K[t];
  endfunction

endpackage

// File: rtl/sha256_block_sched_if.sv
// Control bundle between the front end (master) and the block sequencer (slave).
interface sha256_block_sched_if #(
  parameter int CNT_W = sha256_pkg::CNT_W
);

  logic                   start;
  logic                   init;
  logic                   abort;
  logic                   msg_valid;
  logic                   msg_ready;
  logic                   core_load_iv;
  logic                   core_round_en;
  logic                   core_wsel;
  sha256_pkg::round_idx_t round_idx;
  logic                   core_final_add;
  logic                   busy;
  logic                   done;
  logic                   irq;
  logic                   irq_ack;
  logic [CNT_W-1:0]       block_cnt;

  modport master (
    output start, init, abort, msg_valid, irq_ack,
    input  msg_ready, core_load_iv, core_round_en, core_wsel, round_idx,
           core_final_add, busy, done, irq, block_cnt
  );

  modport slave (
    input  start, init, abort, msg_valid, irq_ack,
    output msg_ready, core_load_iv, core_round_en, core_wsel, round_idx,
           core_final_add, busy, done, irq, block_cnt
  );

endinterface

// File: rtl/sha256_irq_reg.sv
// Level interrupt latch: set by an event strobe, cleared by acknowledge; set wins a tie.
module sha256_irq_reg (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set,
  input  logic i_ack,
  output logic o_irq
);

  logic r_irq;

  // An event coinciding with an acknowledge must not be lost
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else if (i_set) begin
      r_irq <= 1'b1;
    end else if (i_ack) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq;
    end
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/sha256_block_sched.sv
// Per-block sequencer for the SHA-256 round core: optional IV load, 16-word message
// fill, schedule expansion to round 63, final hash add, then done/irq.
module sha256_block_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS    = sha256_pkg::ROUNDS,
  parameter int MSG_WORDS = sha256_pkg::MSG_WORDS,
  parameter int CNT_W     = sha256_pkg::CNT_W
) (
  input logic                 ACLK,
  input logic                 ARESET,
  sha256_block_sched_if.slave bus
);

  localparam round_idx_t LAST_FILL  = round_idx_t'(MSG_WORDS - 1);
  localparam round_idx_t LAST_ROUND = round_idx_t'(ROUNDS - 1);

  sha256_sched_state_t r_state;
  sha256_sched_state_t w_state_nxt;
  round_idx_t          r_round;
  round_idx_t          w_round_nxt;
  logic [CNT_W-1:0]    r_block_cnt;
  logic [CNT_W-1:0]    w_block_cnt_nxt;

  logic r_load_iv, r_expand, r_final_add, r_done, r_busy;
  logic w_load_iv_nxt, w_expand_nxt, w_final_add_nxt, w_done_nxt, w_busy_nxt;
  logic w_fill, w_hs, w_irq;

  assign w_fill = (r_state == ST_FILL);
  assign w_hs   = w_fill & bus.msg_valid;

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks every other transition, DONE always completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = bus.init ? ST_LOAD_IV : ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD_IV: begin
        w_state_nxt = bus.abort ? ST_IDLE : ST_FILL;
      end
      ST_FILL: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hs && (r_round == LAST_FILL)) begin
          w_state_nxt = ST_EXPAND;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_EXPAND: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_round == LAST_ROUND) begin
          w_state_nxt = ST_FINAL;
        end else begin
          w_state_nxt = ST_EXPAND;
        end
      end
      ST_FINAL: begin
        w_state_nxt = bus.abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Round index and completed-block counter next values
  always_comb begin
    w_round_nxt     = r_round;
    w_block_cnt_nxt = r_block_cnt;
    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD_IV)) begin
      w_round_nxt = 6'd0;
    end else if (w_hs || ((r_state == ST_EXPAND) && (r_round != LAST_ROUND))) begin
      w_round_nxt = r_round + 6'd1;
    end else begin
      w_round_nxt = r_round;
    end
    if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOAD_IV)) begin
      w_block_cnt_nxt = {CNT_W{1'b0}};
    end else if ((r_state == ST_FINAL) && (w_state_nxt == ST_DONE)) begin
      w_block_cnt_nxt = r_block_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_block_cnt_nxt = r_block_cnt;
    end
  end

  // Output decode from the next state so the strobes come straight off flops
  always_comb begin
    w_load_iv_nxt   = 1'b0;
    w_expand_nxt    = 1'b0;
    w_final_add_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_LOAD_IV: w_load_iv_nxt   = 1'b1;
      ST_EXPAND:  w_expand_nxt    = 1'b1;
      ST_FINAL:   w_final_add_nxt = 1'b1;
      ST_DONE:    w_done_nxt      = 1'b1;
      default:    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    endcase
  end

  // Output, round and counter registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_load_iv   <= 1'b0;
      r_expand    <= 1'b0;
      r_final_add <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_round     <= 6'd0;
      r_block_cnt <= {CNT_W{1'b0}};
    end else begin
      r_load_iv   <= w_load_iv_nxt;
      r_expand    <= w_expand_nxt;
      r_final_add <= w_final_add_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_round     <= w_round_nxt;
      r_block_cnt <= w_block_cnt_nxt;
    end
  end

  sha256_irq_reg u_irq (
    .i_clk (ACLK),
    .i_rst (ARESET),
    .i_set (r_done),
    .i_ack (bus.irq_ack),
    .o_irq (w_irq)
  );

  // A fill round runs in the very cycle its word is handed over
  assign bus.msg_ready      = w_fill;
  assign bus.core_round_en  = w_hs | r_expand;
  assign bus.core_wsel      = r_expand;
  assign bus.core_load_iv   = r_load_iv;
  assign bus.core_final_add = r_final_add;
  assign bus.round_idx      = r_round;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.irq            = w_irq;
  assign bus.block_cnt      = r_block_cnt;

endmodule
